// File: rtl/ro_coherency_manager.sv
// Read-side coherency manager: polls the peer's remote pointer word over TRI.
// Optional macro RO_COHERENCY_INV_SHORTCUT_EN lets invalidations cut backoff short.
package dcp_pkg;
  typedef logic [39:0] paddr_t;
  typedef logic [4:0]  tri_req_type_t;
  typedef logic [3:0]  tri_resp_type_t;
  localparam tri_req_type_t  TRI_LOAD_RQ  = 5'b00000;
  localparam tri_resp_type_t TRI_LOAD_RET = 4'b0000;
  localparam tri_resp_type_t TRI_INV_RQ   = 4'b0011;
  localparam tri_resp_type_t TRI_ST_ACK   = 4'b0100;
endpackage

package fifo_ctrl_pkg;
  typedef logic [7:0] ptr_t;
endpackage

interface tri_if;
  import dcp_pkg::*;
  logic           req_valid;
  tri_req_type_t  req_type;
  logic [3:0]     req_amo_op;
  logic [2:0]     req_size;
  paddr_t         req_addr;
  logic [63:0]    req_data;
  logic           req_ack;
  logic           resp_val;
  tri_resp_type_t resp_type;
  logic [63:0]    resp_data;
  logic           resp_ack;

  modport master (
    output req_valid, req_type, req_amo_op,
    output req_size, req_addr, req_data,
    output resp_ack,
    input  req_ack, resp_val, resp_type,
    input  resp_data
  );
endinterface

module ro_coherency_manager
  import dcp_pkg::*;
#(
  parameter int PTR_W = $bits(fifo_ctrl_pkg::ptr_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             monitor_on,
  input  logic             clear,
  input  paddr_t           base_addr_r,
  input  logic [15:0]      backoff_value,
  tri_if.master            tri_l2,
  output logic [PTR_W-1:0] remote_ptr_r,
  output logic             remote_valid,
  output logic             element_fetched
);

  typedef enum logic [1:0] {
    S_IDLE, S_BACKOFF, S_REQ, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bo_q, bo_d;
  logic        inv_pending;
  logic        load_ret;
  logic        inv_seen;
  logic        is_new;
  logic [PTR_W-1:0] new_ptr;

  // Returns outside S_RESP belong to an abandoned load and are dropped.
  assign load_ret = tri_l2.resp_val
                 && (tri_l2.resp_type == TRI_LOAD_RET)
                 && (state_q == S_RESP);
  assign inv_seen = tri_l2.resp_val
                 && (tri_l2.resp_type == TRI_INV_RQ);
  assign new_ptr  = tri_l2.resp_data[PTR_W-1:0];
  assign is_new   = !remote_valid || (new_ptr != remote_ptr_r);

  assign tri_l2.req_valid  = (state_q == S_REQ);
  assign tri_l2.req_type   = TRI_LOAD_RQ;
  assign tri_l2.req_size   = 3'b011;
  assign tri_l2.req_addr   = base_addr_r;
  assign tri_l2.req_data   = '0;
  assign tri_l2.req_amo_op = '0;
  assign tri_l2.resp_ack   = 1'b1;

  always_comb begin
    state_d = state_q;
    bo_d    = bo_q;
    unique case (state_q)
      S_IDLE: begin
        if (monitor_on) begin
          state_d = S_BACKOFF;
          bo_d    = backoff_value;
        end
      end
      S_BACKOFF: begin
        if (!monitor_on)
          state_d = S_IDLE;
        else if ((bo_q == 16'd0) || inv_pending)
          state_d = S_REQ;
        else
          bo_d = bo_q - 16'd1;
      end
      S_REQ: begin
        if (tri_l2.req_ack) state_d = S_RESP;
      end
      S_RESP: begin
        if (load_ret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bo_q    <= '0;
    end else begin
      state_q <= state_d;
      bo_q    <= bo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remote_ptr_r    <= '0;
      remote_valid    <= 1'b0;
      element_fetched <= 1'b0;
    end else if (clear) begin
      remote_ptr_r    <= '0;
      remote_valid    <= 1'b0;
      element_fetched <= 1'b0;
    end else begin
      element_fetched <= load_ret && is_new;
      if (load_ret && is_new) begin
        remote_ptr_r <= new_ptr;
        remote_valid <= 1'b1;
      end
    end
  end

`ifdef RO_COHERENCY_INV_SHORTCUT_EN
  // A fresh invalidation outranks the clear-on-entry so it still forces a poll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inv_pending <= 1'b0;
    else if (clear)
      inv_pending <= 1'b0;
    else if (inv_seen)
      inv_pending <= 1'b1;
    else if ((state_d == S_REQ) && (state_q != S_REQ))
      inv_pending <= 1'b0;
  end
`else
  assign inv_pending = 1'b0;
`endif

endmodule

// File: tb/tb_ro_coherency_manager.sv
// Directed bench for ro_coherency_manager.
module tb_ro_coherency_manager;
  import dcp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        monitor_on = 1'b0;
  logic        clear = 1'b0;
  paddr_t      base_addr_r = 40'h12_3456_7840;
  logic [15:0] backoff_value = 16'd3;
  logic [7:0]  remote_ptr_r;
  logic        remote_valid;
  logic        element_fetched;
  int          tests = 0;
  int          fails = 0;

  tri_if t ();

  ro_coherency_manager dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .monitor_on      (monitor_on),
    .clear           (clear),
    .base_addr_r     (base_addr_r),
    .backoff_value   (backoff_value),
    .tri_l2          (t),
    .remote_ptr_r    (remote_ptr_r),
    .remote_valid    (remote_valid),
    .element_fetched (element_fetched)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max, output int cyc);
    cyc = max + 1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (t.req_valid === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic ack_req();
    t.req_ack = 1'b1;
    step();
    t.req_ack = 1'b0;
  endtask

  task automatic load_return(input logic [63:0] d);
    t.resp_val  = 1'b1;
    t.resp_type = TRI_LOAD_RET;
    t.resp_data = d;
    step();
    t.resp_val  = 1'b0;
  endtask

  task automatic poll(input logic [63:0] d);
    int c;
    wait_req(300, c);
    tests++;
    if (c > 300) begin
      fails++;
      $display("FAIL poll_timeout: cycles %0d limit 300", c);
    end
    ack_req();
    load_return(d);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({remote_ptr_r, remote_valid, element_fetched, t.req_valid} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h want 0",
               {remote_ptr_r, remote_valid, element_fetched, t.req_valid});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_poll();
    int c;
    monitor_on    = 1'b1;
    backoff_value = 16'd3;
    wait_req(20, c);
    tests++;
    if (c !== 5) begin
      fails++;
      $display("FAIL first_req_cycle: got %0d want 5", c);
    end
    tests++;
    if (t.req_addr !== base_addr_r || t.req_type !== TRI_LOAD_RQ
        || t.req_size !== 3'b011) begin
      fails++;
      $display("FAIL req_fields: addr %0h type %0h size %0h want %0h 0 3",
               t.req_addr, t.req_type, t.req_size, base_addr_r);
    end
    ack_req();
    tests++;
    if (t.req_valid !== 1'b0) begin
      fails++;
      $display("FAIL req_drop_after_ack: got %b want 0", t.req_valid);
    end
  endtask

  task automatic test_load_new();
    load_return(64'h5);
    tests++;
    if (remote_ptr_r !== 8'h05 || remote_valid !== 1'b1 || element_fetched !== 1'b1) begin
      fails++;
      $display("FAIL load_new: ptr %0h valid %b pulse %b want 5 1 1",
               remote_ptr_r, remote_valid, element_fetched);
    end
    step();
    tests++;
    if (element_fetched !== 1'b0) begin
      fails++;
      $display("FAIL pulse_width: got %b want 0", element_fetched);
    end
  endtask

  task automatic test_equal();
    int c;
    wait_req(20, c);
    tests++;
    if (c !== 4) begin
      fails++;
      $display("FAIL repoll_cycle: got %0d want 4", c);
    end
    ack_req();
    load_return(64'h5);
    tests++;
    if (element_fetched !== 1'b0 || remote_ptr_r !== 8'h05) begin
      fails++;
      $display("FAIL equal_value: pulse %b ptr %0h want 0 5",
               element_fetched, remote_ptr_r);
    end
  endtask

  task automatic test_wrap();
    poll(64'hFF);
    tests++;
    if (element_fetched !== 1'b1 || remote_ptr_r !== 8'hFF) begin
      fails++;
      $display("FAIL max_value: pulse %b ptr %0h want 1 ff",
               element_fetched, remote_ptr_r);
    end
    poll(64'hABCD_0000);
    tests++;
    if (element_fetched !== 1'b1 || remote_ptr_r !== 8'h00 || remote_valid !== 1'b1) begin
      fails++;
      $display("FAIL wrap_value: pulse %b ptr %0h valid %b want 1 0 1",
               element_fetched, remote_ptr_r, remote_valid);
    end
  endtask

  task automatic test_inv_shortcut();
    int c;
    int n;
    int exp_n;
`ifdef RO_COHERENCY_INV_SHORTCUT_EN
    exp_n = 2;
`else
    exp_n = 97;
`endif
    backoff_value = 16'd100;
    step();
    repeat (4) step();
    t.resp_val  = 1'b1;
    t.resp_type = TRI_INV_RQ;
    t.resp_data = 64'h0;
    step();
    t.resp_val  = 1'b0;
    n = 1;
    if (t.req_valid !== 1'b1) begin
      wait_req(200, c);
      n = n + c;
    end
    tests++;
    if (n !== exp_n) begin
      fails++;
      $display("FAIL inv_shortcut: req after %0d cycles want %0d", n, exp_n);
    end
    ack_req();
    load_return(64'h21);
    tests++;
    if (remote_ptr_r !== 8'h21 || element_fetched !== 1'b1) begin
      fails++;
      $display("FAIL inv_load: ptr %0h pulse %b want 21 1",
               remote_ptr_r, element_fetched);
    end
  endtask

  task automatic test_monitor_drop();
    int c;
    int seen;
    backoff_value = 16'd2;
    wait_req(20, c);
    monitor_on = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (t.req_valid === 1'b1) seen++;
    end
    tests++;
    if (seen !== 3) begin
      fails++;
      $display("FAIL req_held: high %0d cycles want 3", seen);
    end
    ack_req();
    load_return(64'h33);
    tests++;
    if (remote_ptr_r !== 8'h33 || element_fetched !== 1'b1) begin
      fails++;
      $display("FAIL drop_load: ptr %0h pulse %b want 33 1",
               remote_ptr_r, element_fetched);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (t.req_valid !== 1'b0) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL no_req_when_off: req_valid high %0d cycles want 0", seen);
    end
  endtask

  task automatic test_clear_collision();
    int c;
    monitor_on    = 1'b1;
    backoff_value = 16'd1;
    wait_req(20, c);
    ack_req();
    clear = 1'b1;
    load_return(64'h9);
    clear = 1'b0;
    tests++;
    if (remote_ptr_r !== 8'h00 || remote_valid !== 1'b0 || element_fetched !== 1'b0) begin
      fails++;
      $display("FAIL clear_wins: ptr %0h valid %b pulse %b want 0 0 0",
               remote_ptr_r, remote_valid, element_fetched);
    end
    step();
    tests++;
    if (element_fetched !== 1'b0 || remote_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_after: pulse %b valid %b want 0 0",
               element_fetched, remote_valid);
    end
  endtask

  task automatic test_async_reset();
    int c;
    poll(64'h44);
    tests++;
    if (remote_ptr_r !== 8'h44 || element_fetched !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_load: ptr %0h pulse %b want 44 1",
               remote_ptr_r, element_fetched);
    end
    wait_req(20, c);
    ack_req();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({remote_ptr_r, remote_valid, element_fetched, t.req_valid} !== 11'd0) begin
      fails++;
      $display("FAIL async_reset: got %0h want 0",
               {remote_ptr_r, remote_valid, element_fetched, t.req_valid});
    end
    monitor_on = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    load_return(64'h77);
    tests++;
    if (remote_valid !== 1'b0 || element_fetched !== 1'b0 || remote_ptr_r !== 8'h00) begin
      fails++;
      $display("FAIL late_return: valid %b pulse %b ptr %0h want 0 0 0",
               remote_valid, element_fetched, remote_ptr_r);
    end
  endtask

  initial begin
    t.req_ack   = 1'b0;
    t.resp_val  = 1'b0;
    t.resp_type = TRI_ST_ACK;
    t.resp_data = 64'h0;
    test_reset();
    test_first_poll();
    test_load_new();
    test_equal();
    test_wrap();
    test_inv_shortcut();
    test_monitor_drop();
    test_clear_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
